ser_to_word_rx: RTL and testbench
=================================

// Module: ser_to_word_rx
// PURPOSE
//  Receive-side counterpart of the 32-bit -> 8-bit -> serial transmit chain.
//  Samples the 1-bit serial stream on t_clk and finds byte alignment using a
//  repeated sync byte. Reassembles 4 aligned bytes into one 32-bit word with a valid pulse.
//  Sits directly downstream of the serializer output, in the t_clk domain.
// PARAMETERS
//  SYNC_BYTE  8'hBC  idle/alignment byte; the transmitter sends it between words
//  SYNC_CNT   3      consecutive aligned SYNC_BYTEs needed to declare lock (1..15)
// PORTS
//  t_clk       in   1   serial bit clock; all logic on rising edge
//  rst_n       in   1   synchronous active-low reset
//  rx_in       in   1   serial data, MSB of each byte first, one bit per t_clk
//  resync      in   1   1-cycle pulse: drop lock and return to HUNT
//  word_out    out  32  assembled word; first received byte in [31:24]
//  word_valid  out  1   1-cycle pulse: word_out holds a new word
//  locked      out  1   high while in DATA state
// BEHAVIOUR
//  Reset (rst_n==0 at edge): sr=0, bit_cnt=0, byte_idx=0, sync_cnt=0, state=HUNT.
//   Outputs: word_out=0, word_valid=0, locked=0. Reset wins over every other input.
//  Shift reg: sr <= {sr[6:0], rx_in} every cycle, in all states. nxt = {sr[6:0], rx_in}.
//  byte_done: asserted in the cycle where bit_cnt==7. bit_cnt counts 0..7 and wraps.
//  States:
//   HUNT  : bit_cnt is ignored. If nxt==SYNC_BYTE: bit_cnt<=0, sync_cnt<=1.
//           Next state is DATA if SYNC_CNT==1, else CHECK.
//   CHECK : on byte_done, if nxt==SYNC_BYTE then sync_cnt++.
//           When sync_cnt+1==SYNC_CNT: go to DATA and set locked<=1.
//           On byte_done with nxt!=SYNC_BYTE: go to HUNT, sync_cnt<=0.
//   DATA  : on byte_done with byte_idx==0 and nxt==SYNC_BYTE: idle byte, discarded.
//           Any other byte_done: store nxt in word lane byte_idx.
//           byte_idx 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
//           byte_idx++ and wraps after 3. Bytes 1..3 are taken verbatim, even if they equal SYNC_BYTE.
//           When byte_idx==3 at byte_done: word_out<={w[31:8],nxt} and word_valid<=1 for 1 cycle.
//  Latency: word_valid is high in the cycle after the edge that samples the last bit
//   (bit 0) of byte 3. word_out holds its value until the next word completes.
//  resync=1 (not in reset): state<=HUNT, locked<=0, byte_idx<=0, sync_cnt<=0.
//   A partial word is dropped. word_out is unchanged and word_valid<=0.
//   If resync and a word completion occur in the same cycle, resync wins and no pulse is issued.
//  No loss-of-lock detection in DATA. Realignment happens only through resync or reset.
//  Back-to-back words with no idle byte between them are allowed: one word every 32 cycles.
// TESTING
//  1) Reset, then idle stream of 0xBC x3 followed by bytes 12 34 56 78.
//     Required: locked rises at the edge after the 3rd 0xBC.
//     word_out=32'h12345678 with a 1-cycle word_valid, 32 cycles after the first data bit.
//  2) Stream preceded by 3 random garbage bits (misaligned), then 0xBC x3, then DEADBEEF.
//     Required: lock acquired, word_out=32'hDEADBEEF.
//  3) After lock, send BC, BC, then words 01BC02BC and CAFEF00D back-to-back.
//     Required: two word_valid pulses exactly 32 cycles apart, words 32'h01BC02BC then 32'hCAFEF00D.
//  4) In CHECK after two 0xBC, send 0x00.
//     Required: state returns to HUNT, locked stays 0.
//     Then 0xBC x3 relocks correctly.
//  5) Pulse resync after 2 bytes of a word.
//     Required: no word_valid, locked=0 next cycle, word_out unchanged.
//     Relock and the next word are correct.
//  6) Assert rst_n=0 mid-word.
//     Required: all outputs 0 at the next edge, and locking restarts from HUNT.

Source files
------------

// File: rtl/ser_to_word_rx.sv
// Serial-to-word receiver: aligns on a repeated sync byte, then packs four
// MSB-first bytes into a 32-bit word with a one-cycle valid pulse.
module ser_to_word_rx #(
    parameter logic [7:0]  SYNC_BYTE = 8'hBC,
    parameter int unsigned SYNC_CNT  = 3
) (
    input  logic        t_clk,
    input  logic        rst_n,
    input  logic        rx_in,
    input  logic        resync,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        locked
);

    typedef enum logic [1:0] {HUNT, CHECK, DATA} state_t;

    localparam logic [3:0] SYNC_TARGET = 4'(SYNC_CNT);

    // Only the low 7 bits of the shift history are ever needed to form the next byte.
    logic [6:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_byte_idx;
    logic [3:0]  r_sync_cnt;
    state_t      r_state;
    logic [31:8] r_acc;
    logic [31:0] r_word;
    logic        r_valid;
    logic        r_locked;

    logic [7:0]  w_nxt;
    logic        w_byte_done;
    logic        w_is_sync;

    assign w_nxt       = {r_sr, rx_in};
    assign w_byte_done = (r_bit_cnt == 3'd7);
    assign w_is_sync   = (w_nxt == SYNC_BYTE);

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign locked     = r_locked;

    always_ff @(posedge t_clk) begin
        if (!rst_n) begin
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_sync_cnt <= '0;
            r_state    <= HUNT;
            r_acc      <= '0;
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_sr      <= w_nxt[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_valid   <= 1'b0;

            if (resync) begin
                r_state    <= HUNT;
                r_locked   <= 1'b0;
                r_byte_idx <= '0;
                r_sync_cnt <= '0;
            end else begin
                case (r_state)
                    HUNT: begin
                        // A sync match at any bit position defines the byte boundary.
                        if (w_is_sync) begin
                            r_bit_cnt  <= '0;
                            r_sync_cnt <= 4'd1;
                            r_byte_idx <= '0;
                            if (SYNC_CNT == 1) begin
                                r_state  <= DATA;
                                r_locked <= 1'b1;
                            end else begin
                                r_state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (w_byte_done) begin
                            if (w_is_sync) begin
                                r_sync_cnt <= r_sync_cnt + 4'd1;
                                if (r_sync_cnt + 4'd1 == SYNC_TARGET) begin
                                    r_state    <= DATA;
                                    r_locked   <= 1'b1;
                                    r_byte_idx <= '0;
                                end
                            end else begin
                                r_state    <= HUNT;
                                r_sync_cnt <= '0;
                            end
                        end
                    end
                    DATA: begin
                        // Sync bytes are idle filler only at a word boundary.
                        if (w_byte_done && !(r_byte_idx == 2'd0 && w_is_sync)) begin
                            case (r_byte_idx)
                                2'd0: r_acc[31:24] <= w_nxt;
                                2'd1: r_acc[23:16] <= w_nxt;
                                2'd2: r_acc[15:8]  <= w_nxt;
                                default: begin
                                    r_word  <= {r_acc[31:8], w_nxt};
                                    r_valid <= 1'b1;
                                end
                            endcase
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser_to_word_rx.sv
// Directed bench for ser_to_word_rx: lock acquisition, word assembly,
// idle-byte handling, resync and reset behaviour.
module tb_ser_to_word_rx;

    logic        t_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_in = 1'b0;
    logic        resync = 1'b0;
    logic [31:0] word_out;
    logic        word_valid;
    logic        locked;

    int checks = 0;
    int failures = 0;
    int edgeCnt = 0;
    logic [31:0] wordQ[$];
    int          edgeQ[$];

    ser_to_word_rx #(.SYNC_BYTE(8'hBC), .SYNC_CNT(3)) dut (
        .t_clk      (t_clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .resync     (resync),
        .word_out   (word_out),
        .word_valid (word_valid),
        .locked     (locked)
    );

    always #10 t_clk = ~t_clk;

    always @(posedge t_clk) edgeCnt = edgeCnt + 1;

    // Every cycle with word_valid high is logged, so a stretched pulse shows up as extra entries.
    always @(negedge t_clk) begin
        if (word_valid === 1'b1) begin
            wordQ.push_back(word_out);
            edgeQ.push_back(edgeCnt);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation still running, required finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", tag, observed, expected);
        end
    endtask

    task automatic sendBit(input logic b, input logic rs);
        @(negedge t_clk);
        rx_in  = b;
        resync = rs;
        @(posedge t_clk);
        #1;
        resync = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) sendBit(v[i], 1'b0);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) sendByte(w[8*k +: 8]);
    endtask

    task automatic lockUp();
        repeat (3) sendByte(8'hBC);
    endtask

    task automatic applyReset(input string tag);
        @(negedge t_clk);
        rst_n = 1'b0;
        rx_in = 1'b0;
        @(posedge t_clk);
        #1;
        checkOutput({tag, "_word"}, word_out, 32'h0);
        checkOutput({tag, "_valid"}, {31'h0, word_valid}, 32'h0);
        checkOutput({tag, "_locked"}, {31'h0, locked}, 32'h0);
        @(negedge t_clk);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus();
        logic [7:0] sb;
        int n0;
        int firstEdge;
        sb = 8'hBC;

        // Test 1: aligned idle then 12345678
        applyReset("t1_rst");
        sendByte(8'hBC);
        sendByte(8'hBC);
        checkOutput("t1_lock_after2", {31'h0, locked}, 32'h0);
        for (int i = 7; i >= 1; i--) sendBit(sb[i], 1'b0);
        checkOutput("t1_lock_before_last_bit", {31'h0, locked}, 32'h0);
        sendBit(sb[0], 1'b0);
        checkOutput("t1_lock_rise", {31'h0, locked}, 32'h1);
        n0 = wordQ.size();
        firstEdge = edgeCnt + 1;
        sendWord(32'h12345678);
        checkOutput("t1_valid_now", {31'h0, word_valid}, 32'h1);
        sendByte(8'hBC);
        checkOutput("t1_pulse_count", wordQ.size() - n0, 32'd1);
        if (wordQ.size() > n0) begin
            checkOutput("t1_word", wordQ[n0], 32'h12345678);
            checkOutput("t1_latency", edgeQ[n0] - firstEdge, 32'd31);
        end
        checkOutput("t1_word_hold", word_out, 32'h12345678);

        // Test 3: idle bytes, then two back-to-back words containing sync values
        sendByte(8'hBC);
        sendByte(8'hBC);
        n0 = wordQ.size();
        sendWord(32'h01BC02BC);
        sendWord(32'hCAFEF00D);
        sendByte(8'hBC);
        checkOutput("t3_pulse_count", wordQ.size() - n0, 32'd2);
        if (wordQ.size() >= n0 + 2) begin
            checkOutput("t3_word0", wordQ[n0], 32'h01BC02BC);
            checkOutput("t3_word1", wordQ[n0+1], 32'hCAFEF00D);
            checkOutput("t3_spacing", edgeQ[n0+1] - edgeQ[n0], 32'd32);
        end

        // Test 2: misaligned garbage bits before the sync bytes
        applyReset("t2_rst");
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        lockUp();
        checkOutput("t2_locked", {31'h0, locked}, 32'h1);
        n0 = wordQ.size();
        sendWord(32'hDEADBEEF);
        sendByte(8'hBC);
        checkOutput("t2_pulse_count", wordQ.size() - n0, 32'd1);
        checkOutput("t2_word", word_out, 32'hDEADBEEF);

        // Test 4: broken sync run in CHECK falls back to HUNT
        applyReset("t4_rst");
        sendByte(8'hBC);
        sendByte(8'hBC);
        sendByte(8'h00);
        checkOutput("t4_lock_after_00", {31'h0, locked}, 32'h0);
        sendByte(8'hBC);
        sendByte(8'hBC);
        checkOutput("t4_lock_after_2_new", {31'h0, locked}, 32'h0);
        sendByte(8'hBC);
        checkOutput("t4_relock", {31'h0, locked}, 32'h1);
        sendWord(32'hA5C3F00F);
        sendByte(8'hBC);
        checkOutput("t4_word", word_out, 32'hA5C3F00F);

        // Test 5: resync mid-word, then resync colliding with completion
        n0 = wordQ.size();
        sendByte(8'h11);
        sendByte(8'h22);
        sendBit(1'b0, 1'b1);
        checkOutput("t5_locked_drop", {31'h0, locked}, 32'h0);
        checkOutput("t5_word_kept", word_out, 32'hA5C3F00F);
        checkOutput("t5_no_pulse", wordQ.size() - n0, 32'd0);
        lockUp();
        checkOutput("t5_relock", {31'h0, locked}, 32'h1);
        sendWord(32'h0F1E2D3C);
        sendByte(8'hBC);
        checkOutput("t5_word_after", word_out, 32'h0F1E2D3C);
        n0 = wordQ.size();
        sendByte(8'h44);
        sendByte(8'h55);
        sendByte(8'h66);
        sb = 8'h77;
        for (int i = 7; i >= 1; i--) sendBit(sb[i], 1'b0);
        sendBit(sb[0], 1'b1);
        sendByte(8'h00);
        checkOutput("t5_collide_no_pulse", wordQ.size() - n0, 32'd0);
        checkOutput("t5_collide_word", word_out, 32'h0F1E2D3C);
        checkOutput("t5_collide_locked", {31'h0, locked}, 32'h0);

        // Test 6: reset in the middle of a word restarts locking from HUNT
        lockUp();
        checkOutput("t6_locked", {31'h0, locked}, 32'h1);
        sendByte(8'h12);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        applyReset("t6_rst");
        sendByte(8'hBC);
        sendByte(8'hBC);
        checkOutput("t6_lock_after2", {31'h0, locked}, 32'h0);
        sendByte(8'hBC);
        checkOutput("t6_relock", {31'h0, locked}, 32'h1);
        n0 = wordQ.size();
        sendWord(32'h89ABCDEF);
        sendByte(8'hBC);
        checkOutput("t6_pulse_count", wordQ.size() - n0, 32'd1);
        checkOutput("t6_word", word_out, 32'h89ABCDEF);
    endtask

    initial begin
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
